occupancy_controller: RTL and testbench
=======================================

# occupancy_controller

Sequencing controller that sits downstream of the two per-sensor debouncers at the lot gate. It decodes the ordered blocking pattern of beam sensors A (outer) and B (inner) into complete car-entry and car-exit events. It rejects partial, reversed and stalled passages, and maintains a saturating occupancy count with full and empty flags for the display and gate-logic blocks.

## Interface
- CAPACITY, 99: maximum occupancy; the count saturates here.
- CNT_W, 7: count width; must satisfy 2^CNT_W > CAPACITY.
- TIMEOUT, 199_999_999: stall limit in clock cycles (2 s at 100 MHz).
- TMR_W, 28: stall-timer width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sensor_a  input  1  debounced outer beam, 1 = blocked; synchronous to clk.
- sensor_b  input  1  debounced inner beam, 1 = blocked; synchronous to clk.
- car_enter  output  1  one-cycle pulse for each completed entry.
- car_exit  output  1  one-cycle pulse for each completed exit.
- abort  output  1  one-cycle pulse when a passage is abandoned by timeout or an illegal pattern.
- count  output  CNT_W  current occupancy.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.

## Operation
- The input pattern is written {a,b}. Legal entry sequence: 00→10→11→01→00. Exit is the mirror: 00→01→11→10→00.
- States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR.
- IDLE:
  - 10→EN1.
  - 01→EX1.
  - 11→WAIT_CLR with abort.
  - 00 stays.
- EN1 (10):
  - 11→EN2.
  - 00→IDLE (car backed out; no pulse).
  - 01→WAIT_CLR with abort.
- EN2 (11):
  - 01→EN3.
  - 10→EN1.
  - 00→WAIT_CLR with abort.
- EN3 (01):
  - 00→IDLE with car_enter.
  - 11→EN2.
  - 10→WAIT_CLR with abort.
- EX1, EX2 and EX3 mirror EN1, EN2 and EN3 with a and b swapped. EX3 with 00→IDLE raises car_exit.
- WAIT_CLR: stays until 00, then goes to IDLE. Produces no pulses.
- Stall timer:
  - Counts only in EN*/EX* states.
  - Clears to 0 on every state change and while in IDLE or WAIT_CLR.
  - When the timer equals TIMEOUT and the next state would equal the current state, the FSM moves to WAIT_CLR with abort.
  - A legal transition on that same cycle takes priority over the timeout.
- Count:
  - car_enter with count < CAPACITY: increment.
  - car_enter with count == CAPACITY: hold; the car_enter pulse is still emitted.
  - car_exit with count > 0: decrement.
  - car_exit with count == 0: hold; the car_exit pulse is still emitted.
  - car_enter and car_exit are mutually exclusive by construction.
- full and empty are decoded from the count register, so they change in the same cycle as count.

## Timing
- Reset values: state IDLE, timer 0, count 0, car_enter 0, car_exit 0, abort 0, full 0, empty 1.
- Reset has priority over all other activity, including mid-passage; no pulse is generated by reset.
- Inputs are sampled on rising edge N.
  - The state, the pulse outputs and count all update at edge N.
  - Each pulse is high for exactly the cycle following edge N.
  - Latency from the final 00 sample to the pulse and the new count is 1 cycle.
- The stall timeout fires on the edge where the timer reads TIMEOUT. That is TIMEOUT+1 cycles after entering the state with constant inputs.
- Inputs are not synchronised internally. They must come from the clk-domain debouncers.

## Test plan
- Entry: reset, then apply {a,b} = 10, 11, 01, 00, holding each for 5 cycles → exactly one car_enter pulse, one cycle wide; count goes 0→1; empty falls 1→0 in the same cycle.
- Exit with floor: from count 0, apply 01, 11, 10, 00 → car_exit pulses once; count stays 0; empty stays 1. Repeat after one entry → count goes 1→0.
- Back-out and reversal: apply 10, 00 → no pulses, state back to IDLE. Apply 10, 11, 10, 11, 01, 00 → exactly one car_enter.
- Illegal pattern: in IDLE apply 11 → abort pulse. Then 01 → no exit is started (state is WAIT_CLR). Then 00 → IDLE. A subsequent legal exit still counts.
- Timeout (TIMEOUT=15): enter EN2 and hold 11 → abort fires 16 cycles after the EN2 entry. Then 01, 00 → no car_enter. Separately, a transition on the timeout cycle is taken with no abort.
- Saturation and reset (CAPACITY=3): 4 entries → count 3, full=1, and the 4th car_enter still pulses. Assert reset during EN3 → count 0, outputs at reset values, and no car_enter on release.

Source files
------------

// File: rtl/occupancy_controller.sv
// occupancy_controller
// Decodes the ordered blocking pattern of the outer (A) and inner (B) gate
// beams into complete car-entry / car-exit events, rejects partial, reversed
// and stalled passages, and keeps a saturating occupancy count.
module occupancy_controller #(
    parameter int CAPACITY = 99,
    parameter int CNT_W    = 7,
    parameter int TIMEOUT  = 199_999_999,
    parameter int TMR_W    = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic             car_enter,
    output logic             car_exit,
    output logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN1      = 3'd1,
        EN2      = 3'd2,
        EN3      = 3'd3,
        EX1      = 3'd4,
        EX2      = 3'd5,
        EX3      = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);

    state_t             state_r;
    state_t             legal_next_s;
    state_t             next_state_s;
    logic [TMR_W-1:0]   timer_r;
    logic [CNT_W-1:0]   count_r;
    logic               car_enter_r;
    logic               car_exit_r;
    logic               abort_r;
    logic [1:0]         pat_s;
    logic               illegal_s;
    logic               enter_s;
    logic               exit_s;
    logic               in_passage_s;
    logic               timeout_s;
    logic               abort_s;

    assign pat_s = {sensor_a, sensor_b};

    // Pattern decoder: where the passage goes for the current beam pattern, ignoring stalls.
    always_comb begin
        legal_next_s = state_r;
        illegal_s    = 1'b0;
        enter_s      = 1'b0;
        exit_s       = 1'b0;
        case (state_r)
            IDLE: begin
                case (pat_s)
                    2'b10:   legal_next_s = EN1;
                    2'b01:   legal_next_s = EX1;
                    2'b11:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = IDLE;
                endcase
            end
            EN1: begin
                case (pat_s)
                    2'b11:   legal_next_s = EN2;
                    2'b00:   legal_next_s = IDLE;          // car backed out
                    2'b01:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EN1;
                endcase
            end
            EN2: begin
                case (pat_s)
                    2'b01:   legal_next_s = EN3;
                    2'b10:   legal_next_s = EN1;
                    2'b00:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EN2;
                endcase
            end
            EN3: begin
                case (pat_s)
                    2'b00:   begin legal_next_s = IDLE; enter_s = 1'b1; end
                    2'b11:   legal_next_s = EN2;
                    2'b10:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EN3;
                endcase
            end
            EX1: begin
                case (pat_s)
                    2'b11:   legal_next_s = EX2;
                    2'b00:   legal_next_s = IDLE;          // car backed out
                    2'b10:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EX1;
                endcase
            end
            EX2: begin
                case (pat_s)
                    2'b10:   legal_next_s = EX3;
                    2'b01:   legal_next_s = EX1;
                    2'b00:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EX2;
                endcase
            end
            EX3: begin
                case (pat_s)
                    2'b00:   begin legal_next_s = IDLE; exit_s = 1'b1; end
                    2'b11:   legal_next_s = EX2;
                    2'b01:   begin legal_next_s = WAIT_CLR; illegal_s = 1'b1; end
                    default: legal_next_s = EX3;
                endcase
            end
            WAIT_CLR: begin
                if (pat_s == 2'b00) begin
                    legal_next_s = IDLE;
                end else begin
                    legal_next_s = WAIT_CLR;
                end
            end
            default: legal_next_s = IDLE;
        endcase
    end

    // Stall override: a passage stuck in one state for too long is abandoned.
    always_comb begin
        in_passage_s = (state_r != IDLE) && (state_r != WAIT_CLR);
        timeout_s    = 1'b0;
        next_state_s = legal_next_s;
        if (in_passage_s && (legal_next_s == state_r) && (timer_r == TIMEOUT_V)) begin
            timeout_s    = 1'b1;
            next_state_s = WAIT_CLR;
        end else begin
            next_state_s = legal_next_s;
        end
        abort_s = illegal_s | timeout_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Stall timer: runs only while a passage sits in one state.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (!in_passage_s || (next_state_s != state_r)) begin
            timer_r <= {TMR_W{1'b0}};
        end else begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Registered event pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_enter_r <= 1'b0;
            car_exit_r  <= 1'b0;
            abort_r     <= 1'b0;
        end else begin
            car_enter_r <= enter_s;
            car_exit_r  <= exit_s;
            abort_r     <= abort_s;
        end
    end

    // Occupancy count, saturating at 0 and CAPACITY; pulses are emitted regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enter_s && (count_r != CAP_V)) begin
            count_r <= count_r + CNT_W'(1);
        end else if (exit_s && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign car_enter = car_enter_r;
    assign car_exit  = car_exit_r;
    assign abort     = abort_r;
    assign count     = count_r;
    assign full      = (count_r == CAP_V);
    assign empty     = (count_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_occupancy_controller.sv
// Scoreboard bench for occupancy_controller: the driver advances a passage
// model one clock at a time and queues the expected outputs; an independent
// monitor pops and compares them one cycle later.
module tb_occupancy_controller;

    localparam int CAPACITY = 3;
    localparam int CNT_W    = 7;
    localparam int TIMEOUT  = 15;
    localparam int TMR_W    = 28;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sensor_a = 1'b0;
    logic             sensor_b = 1'b0;
    logic             car_enter;
    logic             car_exit;
    logic             abort;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    occupancy_controller #(
        .CAPACITY(CAPACITY), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
        .car_enter(car_enter), .car_exit(car_exit), .abort(abort),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             en;
        logic             ex;
        logic             ab;
        logic [CNT_W-1:0] cnt;
        logic             fl;
        logic             em;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Passage model: mode 0 = no car, 1 = car in the gate, 2 = waiting for clear beams.
    // A passage is a position 0..3 along its direction's pattern list.
    int m_mode  = 0;
    int m_dir   = 1;
    int m_pos   = 0;
    int m_stall = 0;
    int m_count = 0;

    // Position of a pattern along the entry (dir>0) or exit path: 00,first,11,last.
    function automatic int idx_of(input int dir, input logic [1:0] p);
        logic [1:0] q;
        q = (dir > 0) ? p : {p[0], p[1]};
        case (q)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_step(input logic [1:0] p, input logic r);
        exp_t e;
        int   idx;
        int   d;
        e = '0;
        if (r) begin
            m_mode = 0; m_stall = 0; m_count = 0;
        end else if (m_mode == 0) begin
            if (p == 2'b10)      begin m_mode = 1; m_dir = 1;  m_pos = 1; m_stall = 0; end
            else if (p == 2'b01) begin m_mode = 1; m_dir = -1; m_pos = 1; m_stall = 0; end
            else if (p == 2'b11) begin m_mode = 2; e.ab = 1'b1; end
        end else if (m_mode == 1) begin
            idx = idx_of(m_dir, p);
            d   = idx - m_pos;
            if (d == 0) begin
                if (m_stall == TIMEOUT) begin m_mode = 2; e.ab = 1'b1; end
                else m_stall++;
            end else if (d == 1 || d == -1) begin
                if (idx == 0) m_mode = 0;
                m_pos = idx; m_stall = 0;
            end else if (m_pos == 3 && idx == 0) begin
                m_mode = 0;
                if (m_dir > 0) begin
                    e.en = 1'b1;
                    if (m_count < CAPACITY) m_count++;
                end else begin
                    e.ex = 1'b1;
                    if (m_count > 0) m_count--;
                end
            end else begin
                m_mode = 2; e.ab = 1'b1;
            end
        end else begin
            if (p == 2'b00) m_mode = 0;
        end
        e.cnt = CNT_W'(m_count);
        e.fl  = (m_count == CAPACITY);
        e.em  = (m_count == 0);
        exp_q.push_back(e);
    endtask

    // Drive one pattern for n cycles (inputs change on the falling edge).
    task automatic drive(input logic [1:0] p, input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sensor_a = p[1];
            sensor_b = p[0];
            reset    = r;
            model_step(p, r);
        end
    endtask

    task automatic passage(input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] p3);
        drive(p1, 5, 1'b0);
        drive(p2, 5, 1'b0);
        drive(p3, 5, 1'b0);
        drive(2'b00, 5, 1'b0);
    endtask

    function automatic int rh();
        if ($urandom_range(0, 7) == 0) return $urandom_range(14, 18);
        return $urandom_range(1, 5);
    endfunction

    task automatic rand_seq(input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] p3);
        drive(p1, rh(), 1'b0);
        if ($urandom_range(0, 3) == 0) begin
            drive(p2, rh(), 1'b0);
            drive(p1, rh(), 1'b0);
        end
        drive(p2, rh(), 1'b0);
        if ($urandom_range(0, 3) == 0) begin
            drive(p3, rh(), 1'b0);
            drive(p2, rh(), 1'b0);
        end
        drive(p3, rh(), 1'b0);
    endtask

    // Monitor: compare every DUT output cycle with the queued expectation.
    exp_t got;
    exp_t want;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {car_enter, car_exit, abort, count, full, empty};
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL outputs t=%0t: got en=%b ex=%b ab=%b cnt=%0d full=%b empty=%b, expected en=%b ex=%b ab=%b cnt=%0d full=%b empty=%b",
                             $time, got.en, got.ex, got.ab, got.cnt, got.fl, got.em,
                             want.en, want.ex, want.ab, want.cnt, want.fl, want.em);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized passages.
    initial begin
        int kind;
        drive(2'b00, 3, 1'b1);
        drive(2'b00, 2, 1'b0);
        // entry 0 -> 1
        passage(2'b10, 2'b11, 2'b01);
        // exit to floor from 0 after reset, then 1 -> 0
        drive(2'b00, 2, 1'b1);
        drive(2'b00, 2, 1'b0);
        passage(2'b01, 2'b11, 2'b10);
        passage(2'b10, 2'b11, 2'b01);
        passage(2'b01, 2'b11, 2'b10);
        // back-out and reversal
        drive(2'b10, 3, 1'b0);
        drive(2'b00, 3, 1'b0);
        drive(2'b10, 2, 1'b0); drive(2'b11, 2, 1'b0); drive(2'b10, 2, 1'b0);
        drive(2'b11, 2, 1'b0); drive(2'b01, 2, 1'b0); drive(2'b00, 3, 1'b0);
        // illegal pattern from idle, then a legal exit
        drive(2'b11, 3, 1'b0); drive(2'b01, 3, 1'b0); drive(2'b00, 3, 1'b0);
        passage(2'b01, 2'b11, 2'b10);
        // timeout in EN2, then the remainder must not count
        drive(2'b10, 2, 1'b0); drive(2'b11, 20, 1'b0);
        drive(2'b01, 3, 1'b0); drive(2'b00, 3, 1'b0);
        // transition exactly on the timeout cycle is taken
        drive(2'b10, 2, 1'b0); drive(2'b11, TIMEOUT + 1, 1'b0);
        drive(2'b01, 2, 1'b0); drive(2'b00, 3, 1'b0);
        // saturation: four more entries
        for (int i = 0; i < 4; i++) passage(2'b10, 2'b11, 2'b01);
        // reset during EN3
        drive(2'b10, 2, 1'b0); drive(2'b11, 2, 1'b0); drive(2'b01, 2, 1'b0);
        drive(2'b01, 2, 1'b1); drive(2'b00, 4, 1'b0);
        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4)      rand_seq(2'b10, 2'b11, 2'b01);
            else if (kind <= 7) rand_seq(2'b01, 2'b11, 2'b10);
            else if (kind == 8) begin
                for (int j = 0; j < 6; j++) drive(2'($urandom_range(0, 3)), $urandom_range(1, 4), 1'b0);
            end else begin
                drive(2'($urandom_range(0, 3)), 1, 1'b1);
            end
            drive(2'b00, $urandom_range(1, 3), 1'b0);
        end
        @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
